// File: rtl/fsk_pkg.sv
// Shared types and constants for the byte-framed 2FSK transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int          BIT_CYCLES_DEF = 2048;
  localparam logic [31:0] F0_STEP_DEF    = 32'd4194304;   // 2 carrier periods per 2048 clocks
  localparam logic [31:0] F1_STEP_DEF    = 32'd16777216;  // 8 carrier periods per 2048 clocks
  localparam int          SAMPLE_W       = 11;
  localparam int          PHASE_W        = 32;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 11'd1024;

  // Fold the top 12 phase bits into an 11-bit offset-binary triangle.
  function automatic logic [SAMPLE_W-1:0] tri_shape(input logic [PHASE_W-1:0] phase);
    logic [11:0] p;
    p = phase[PHASE_W-1 -: 12];
    return p[11] ? ~p[10:0] : p[10:0];
  endfunction

endpackage

// File: rtl/fsk_nco.sv
// Phase-continuous NCO with triangle shaper producing the modulated sample.
// Latency: sample is the shaped phase register value, one clock behind the phase.
// Backpressure: none; free-running whenever en is high, midscale when en is low.
module fsk_nco
  import fsk_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,   // active-high synchronous reset despite the name
  input  logic                en,
  input  logic [PHASE_W-1:0]  step,
  output logic [SAMPLE_W-1:0] sample
);

  logic [PHASE_W-1:0] phase;

  // Accumulate phase modulo 2^32 and register the shaped sample; phase is never
  // cleared at bit boundaries so tone switches stay continuous.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      phase  <= '0;
      sample <= MIDSCALE;
    end else if (en) begin
      phase  <= phase + step;
      sample <= tri_shape(phase);
    end else begin
      sample <= MIDSCALE;
    end
  end

endmodule

// File: rtl/fsk_tx_mod.sv
// Byte-framed 2FSK transmitter: start bit, 8 data bits LSB-first, stop bit, BIT_CYCLES clocks each.
// Latency: first START cycle follows the accept cycle; sample reflects a new tone one clock later.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is ignored and must be held.
module fsk_tx_mod
  import fsk_pkg::*;
#(
  parameter int          BIT_CYCLES = BIT_CYCLES_DEF,
  parameter logic [31:0] F0_STEP    = F0_STEP_DEF,
  parameter logic [31:0] F1_STEP    = F1_STEP_DEF,
  parameter bit          IDLE_MARK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,        // active-high synchronous reset despite the name
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] data_module,
  output logic        tx_bit,
  output logic        bit_strobe,
  output logic        busy
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             last_cyc;
  logic             nco_en;
  logic [31:0]      nco_step;

  assign last_cyc = (cnt == CNT_LAST);

  // State, cycle counter, bit index and shift register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Framing FSM: next state, counters and line level for the current bit.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    in_ready    = 1'b0;
    busy        = 1'b1;
    tx_bit      = 1'b1;
    if (state != IDLE) begin
      cnt_nxt = last_cyc ? '0 : cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = START;
          cnt_nxt   = '0;
          shift_nxt = in_data;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (last_cyc) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
        end
      end
      DATA: begin
        tx_bit = shift[0];
        if (last_cyc) begin
          shift_nxt   = shift >> 1;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (last_cyc) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bit_strobe = (state != IDLE) && (cnt == '0);

  // With IDLE_MARK clear the idle line parks at midscale and the phase is frozen.
  assign nco_en   = IDLE_MARK || (state != IDLE);
  assign nco_step = tx_bit ? F1_STEP : F0_STEP;

  fsk_nco u_nco (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (nco_en),
    .step   (nco_step),
    .sample (data_module)
  );

endmodule

// File: tb/tb_fsk_tx_mod.sv
// Scoreboarded bench for fsk_tx_mod: the stimulus pushes each accepted frame's bits,
// a monitor runs a frame-position / phase-arithmetic model and compares every cycle.
// Runs with a shortened bit period to keep the run short.
module tb_fsk_tx_mod;
  import fsk_pkg::*;

  localparam int          BC = 128;
  localparam logic [31:0] F0 = F0_STEP_DEF;
  localparam logic [31:0] F1 = F1_STEP_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] data_module;
  logic        tx_bit;
  logic        bit_strobe;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_q[$];
  int max_seen = 0;
  int min_seen = 2047;

  always #5 clk = ~clk;

  fsk_tx_mod #(
    .BIT_CYCLES (BC),
    .F0_STEP    (F0),
    .F1_STEP    (F1),
    .IDLE_MARK  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_module (data_module),
    .tx_bit      (tx_bit),
    .bit_strobe  (bit_strobe),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Triangle from the 12 top phase bits: rising 0..2047 then falling back.
  function automatic int tri_ref(input int unsigned ph);
    int p;
    p = int'(ph >> 20);
    return (p < 2048) ? p : 4095 - p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a byte until accepted; on acceptance queue the expected line bits.
  task automatic send(input logic [7:0] b, input bit hold);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 12 * BC && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !rst_n) begin
        @(posedge clk);
        ok = 1'b1;
        exp_q.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        exp_q.push_back(1'b1);
      end
    end
    #1;
    if (!hold) in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Monitor / reference model.
  initial begin : monitor
    int unsigned ph;
    bit idle, cur, line, r, v;
    int fpos, exp_s, prev_s, d;
    ph = 0; idle = 1; cur = 1; line = 1; fpos = 0; exp_s = 1024; prev_s = -1;
    forever begin
      @(posedge clk);
      r = rst_n;
      v = in_valid;
      if (r) begin
        idle = 1; fpos = 0; ph = 0; exp_s = 1024; prev_s = -1;
        exp_q.delete();
      end else begin
        exp_s = tri_ref(ph);
        ph = ph + (line ? F1 : F0);
        if (idle) begin
          if (v) begin idle = 0; fpos = 0; end
        end else begin
          fpos++;
          if (fpos == 10 * BC) begin idle = 1; fpos = 0; end
        end
      end
      @(negedge clk);
      if (!idle && (fpos % BC) == 0) begin
        if (exp_q.size() == 0) check("queue_underflow", 0, 1);
        else cur = exp_q.pop_front();
      end
      line = idle ? 1'b1 : cur;
      check("in_ready",    in_ready,    idle);
      check("busy",        busy,        !idle);
      check("bit_strobe",  bit_strobe,  (!idle && (fpos % BC) == 0));
      check("tx_bit",      tx_bit,      line);
      check("data_module", data_module, exp_s);
      if (!r) begin
        if (prev_s >= 0) begin
          d = int'(data_module) - prev_s;
          if (d < 0) d = -d;
          check("continuity_le17", (d <= 17), 1);
        end
        prev_s = int'(data_module);
        if (int'(data_module) > max_seen) max_seen = int'(data_module);
        if (int'(data_module) < min_seen) min_seen = int'(data_module);
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] b;
    tick(3);
    rst_n = 1'b0;
    tick(4096);

    send(8'hA5, 1'b0);
    tick(10 * BC + 3);
    send(8'h00, 1'b0);
    tick(10 * BC + 3);
    send(8'hFF, 1'b0);
    tick(10 * BC + 3);

    // Back-to-back with valid held across the busy period.
    send(8'h12, 1'b1);
    send(8'h34, 1'b0);
    tick(10 * BC + 3);

    // Reset in DATA bit 3, together with a valid byte that must not be captured.
    send(8'hC3, 1'b0);
    tick(4 * BC + 7);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick(1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick(5);
    send(8'h3C, 1'b0);
    tick(10 * BC + 3);

    // Random bytes, gaps and back-to-back holds.
    for (int i = 0; i < 16; i++) begin
      bit hold;
      b    = 8'($urandom);
      hold = ($urandom_range(0, 2) == 0);
      send(b, hold);
      if (!hold) tick($urandom_range(0, BC));
    end
    in_valid = 1'b0;
    tick(10 * BC + 4);

    check("queue_empty", exp_q.size(), 0);
    check("peak_max",    max_seen,     2047);
    check("peak_min",    min_seen,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsk_tx_mod.md
Name: fsk_tx_mod

Overview:
- Byte-framed 2FSK transmitter; the transmit end of the existing zero-crossing 2FSK demodulator.
- Accepts bytes over a valid/ready handshake and frames each as UART-style start bit, 8 data bits LSB-first, stop bit.
- Emits a phase-continuous 11-bit offset-binary triangle carrier: low tone for bit 0, high tone for bit 1, one bit per BIT_CYCLES clocks.
- Output feeds the same sample path the demodulator consumes (2048-clock bit window).

Parameters:
- BIT_CYCLES, 2048, clocks per transmitted bit; must match demodulator window.
- F0_STEP, 32'd4194304, phase increment for bit 0 (2 carrier periods per 2048 clocks).
- F1_STEP, 32'd16777216, phase increment for bit 1 (8 carrier periods per 2048 clocks).
- IDLE_MARK, 1, 1 = idle line sends F1 tone; 0 = idle output held at midscale 1024.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-high (asserted = 1) despite the port name.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- data_module  out  11  modulated sample, offset binary, midscale 1024.
- tx_bit  out  1  bit currently being modulated (line level).
- bit_strobe  out  1  one-cycle pulse on the first cycle of each bit period.
- busy  out  1  high from acceptance through the last stop-bit cycle.

Behaviour:
- Reset (rst_n=1 at clk edge) clears the following in the same cycle, aborting any frame mid-bit; no partial byte is resumed:
  - phase=0, state=IDLE, bit counter=0, cycle counter=0.
  - Outputs: in_ready=1, busy=0, bit_strobe=0, tx_bit=1, data_module=1024.
- Handshake:
  - in_ready=1 only in IDLE.
  - Transfer occurs on a cycle with in_valid&in_ready; in_data is latched into a shift register.
  - in_ready drops the next cycle.
  - in_valid while not ready is ignored; the byte is not captured and the source must hold it.
- FSM states:
  - IDLE: on transfer -> START, cycle counter=0, bit_strobe pulses on the first START cycle.
  - START: tx_bit=0 for BIT_CYCLES clocks -> DATA, bit index 0.
  - DATA: tx_bit=shift[0] for BIT_CYCLES clocks, then shift right, index+1; after index 7 completes -> STOP.
  - STOP: tx_bit=1 for BIT_CYCLES clocks -> IDLE. in_ready returns high the cycle after the last STOP cycle. The earliest next START is therefore 1 cycle after re-entering IDLE.
- Cycle counter:
  - Counts 0..BIT_CYCLES-1 and wraps to 0 at bit boundaries.
  - bit_strobe=1 when the count is 0 in START/DATA/STOP.
- Frame length: exactly 10*BIT_CYCLES clocks from the first START cycle to the last STOP cycle.
- NCO:
  - 32-bit phase accumulator, wraps modulo 2^32, never reset between bits (phase-continuous at tone switches).
  - Step = F1_STEP if tx_bit=1, else F0_STEP. In IDLE with IDLE_MARK=1 it accumulates F1_STEP; with IDLE_MARK=0 phase is held.
- Waveform:
  - p = phase[31:20] (12 bits).
  - data_module = p[11] ? ~p[10:0] : p[10:0].
  - Range 0..2047, registered; 1-cycle latency from phase to output.
  - IDLE_MARK=0 in IDLE forces data_module=1024.
- tx_bit changes on the same edge the state/bit changes. data_module reflects the new step from the following cycle.
- Simultaneous reset and in_valid: reset wins, no capture.

Decomposition:
- Package fsk_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - Constants BIT_CYCLES_DEF=2048, F0_STEP_DEF, F1_STEP_DEF, MIDSCALE=11'd1024, SAMPLE_W=11, PHASE_W=32.
- Sub-module fsk_nco:
  - Contains the phase accumulator and triangle shaper.
  - Inputs: clk, rst_n, en, step[31:0]. Output: sample[10:0].
- fsk_tx_mod holds the handshake, FSM, counters and shift register.

Test Plan:
- Reset then idle 4096 cycles (IDLE_MARK=1):
  - During reset: in_ready=1, busy=0, tx_bit=1.
  - After release: data_module completes 16 triangle periods and peaks at 2047/0.
- Send 0xA5 with in_valid for one cycle:
  - in_ready falls the next cycle.
  - tx_bit sequence 0,1,0,1,0,0,1,0,1,1, each held 2048 clocks.
  - 10 bit_strobe pulses; busy high for exactly 20480 cycles.
- Tone check on 0x00 vs 0xFF:
  - Count data_module==1024 crossings per bit window: about 4 for 0-bits, about 16 for 1-bits.
  - Loopback into the demodulator recovers the byte.
- Phase continuity at each tone switch: |Δdata_module| between consecutive cycles ≤ 17 everywhere, including bit boundaries.
- Back-to-back bytes 0x12, 0x34 with in_valid held high:
  - Second byte accepted the first cycle in_ready returns after the STOP bit.
  - No byte lost or duplicated.
- Reset asserted in DATA bit 3:
  - Next cycle: state IDLE, data_module=1024, phase=0, in_ready=1.
  - A new byte sent afterwards transmits correctly.
